// File: rtl/axi4l_replayer.sv
// rtl/axi4l_replayer.sv - AXI4-Lite master that replays logged {rnw, addr, data} entries and checks reads
module axi4l_replayer #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned CHECK_READS    = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                    clk_axi,
  input  logic                    anrst_axi,

  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_rnw,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_data,

  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]              m_axi_arprot,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,

  input  logic                    clear,
  output logic                    busy,
  output logic                    done,
  output logic                    mismatch,
  output logic                    resp_err,
  output logic                    timeout,
  output logic                    sticky_err,
  output logic [CNT_WIDTH-1:0]    txn_cnt,
  output logic [CNT_WIDTH-1:0]    mismatch_cnt,
  output logic [ADDR_WIDTH-1:0]   last_mismatch_addr
);

  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_CYCLES);
  localparam logic [WAIT_W-1:0] WAIT_PRE   = WAIT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_WR_RESP,
    S_RD_REQ,
    S_RD_DATA
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_awvalid;
  logic                  r_wvalid;
  logic                  r_bready;
  logic                  r_arvalid;
  logic                  r_rready;
  logic [WAIT_W-1:0]     r_wait;
  logic [CNT_WIDTH-1:0]  r_txn_cnt;
  logic [CNT_WIDTH-1:0]  r_mismatch_cnt;
  logic                  r_sticky;
  logic [ADDR_WIDTH-1:0] r_last_addr;

  logic w_aw_pend;
  logic w_w_pend;
  logic w_b_fire;
  logic w_r_fire;
  logic w_done;
  logic w_resp_err;
  logic w_mismatch;
  logic w_waiting;
  logic w_timeout;

  // A channel is still pending when its valid is up and the slave has not taken it this cycle.
  assign w_aw_pend  = r_awvalid && !m_axi_awready;
  assign w_w_pend   = r_wvalid && !m_axi_wready;
  assign w_b_fire   = (r_state == S_WR_RESP) && r_bready && m_axi_bvalid;
  assign w_r_fire   = (r_state == S_RD_DATA) && r_rready && m_axi_rvalid;
  assign w_done     = w_b_fire || w_r_fire;
  assign w_resp_err = (w_b_fire && (m_axi_bresp != 2'b00)) ||
                      (w_r_fire && (m_axi_rresp != 2'b00));
  assign w_mismatch = (CHECK_READS != 0) && w_r_fire && (m_axi_rdata != r_data);
  assign w_waiting  = (r_state != S_IDLE);
  // Fires in the cycle whose count step lands on the limit; the counter then holds there.
  assign w_timeout  = w_waiting && (r_wait == WAIT_PRE);

  assign cmd_ready          = (r_state == S_IDLE);
  assign busy               = w_waiting;
  assign done               = w_done;
  assign mismatch           = w_mismatch;
  assign resp_err           = w_resp_err;
  assign timeout            = w_timeout;
  assign sticky_err         = r_sticky;
  assign txn_cnt            = r_txn_cnt;
  assign mismatch_cnt       = r_mismatch_cnt;
  assign last_mismatch_addr = r_last_addr;

  assign m_axi_awaddr  = r_addr;
  assign m_axi_araddr  = r_addr;
  assign m_axi_wdata   = r_data;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_wstrb   = '1;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_bready  = r_bready;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_rready  = r_rready;

  // Transaction FSM: latches the entry, then walks one AXI write or read to completion.
  always_ff @(posedge clk_axi or negedge anrst_axi) begin
    if (!anrst_axi) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_data    <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_addr <= cmd_addr;
            r_data <= cmd_data;
            if (cmd_rnw) begin
              r_arvalid <= 1'b1;
              r_state   <= S_RD_REQ;
            end else begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= S_WR_REQ;
            end
          end
        end
        S_WR_REQ: begin
          if (r_awvalid && m_axi_awready) r_awvalid <= 1'b0;
          if (r_wvalid && m_axi_wready)   r_wvalid  <= 1'b0;
          if (!w_aw_pend && !w_w_pend) begin
            r_bready <= 1'b1;
            r_state  <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (m_axi_bvalid) begin
            r_bready <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        S_RD_REQ: begin
          if (m_axi_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (m_axi_rvalid) begin
            r_rready <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Wait counter: runs while a transaction is outstanding, parks at the limit, zero again in IDLE.
  always_ff @(posedge clk_axi or negedge anrst_axi) begin
    if (!anrst_axi) begin
      r_wait <= '0;
    end else if (!w_waiting || w_done) begin
      r_wait <= '0;
    end else if (r_wait != WAIT_LIMIT) begin
      r_wait <= r_wait + WAIT_W'(1);
    end
  end

  // Status counters and sticky flag; clear takes priority over any same-cycle event.
  always_ff @(posedge clk_axi or negedge anrst_axi) begin
    if (!anrst_axi) begin
      r_txn_cnt      <= '0;
      r_mismatch_cnt <= '0;
      r_sticky       <= 1'b0;
    end else if (clear) begin
      r_txn_cnt      <= '0;
      r_mismatch_cnt <= '0;
      r_sticky       <= 1'b0;
    end else begin
      if (w_done && (r_txn_cnt != '1)) r_txn_cnt <= r_txn_cnt + CNT_WIDTH'(1);
      if (w_mismatch && (r_mismatch_cnt != '1)) r_mismatch_cnt <= r_mismatch_cnt + CNT_WIDTH'(1);
      if (w_mismatch || w_resp_err || w_timeout) r_sticky <= 1'b1;
    end
  end

  // Address of the most recent failed read compare; untouched by clear.
  always_ff @(posedge clk_axi or negedge anrst_axi) begin
    if (!anrst_axi) begin
      r_last_addr <= '0;
    end else if (w_mismatch) begin
      r_last_addr <= r_addr;
    end
  end

endmodule

// File: doc/axi4l_replayer.md
Name: axi4l_replayer

Overview:
- AXI4-Lite master that replays a logged transaction stream onto a register-space slave; it is the driving counterpart of the team's passive AXI4-Lite logger.
- Accepts {rnw, addr, data} entries over a valid/ready command port, with entries typically drained from a logger FIFO.
- Issues one AXI4-Lite write or read per entry and checks each read's returned data against the logged data.
- Reports mismatches, error responses and stalls; used for register-sequence playback and regression against captured traffic.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, AXI data width (multiple of 8).
- CHECK_READS, 1, 1 = compare read data to cmd_data; 0 = no compare.
- TIMEOUT_CYCLES, 1024, wait-state cycles before the timeout flag (>=2).
- CNT_WIDTH, 16, width of the status counters.

Ports:
- clk_axi  in  1  AXI clock; the only clock.
- anrst_axi  in  1  async reset, active low.
- cmd_valid  in  1  command entry valid.
- cmd_ready  out  1  entry accepted when valid&&ready.
- cmd_rnw  in  1  1 = read, 0 = write.
- cmd_addr  in  ADDR_WIDTH  target address.
- cmd_data  in  DATA_WIDTH  write data, or expected read data.
- m_axi_awaddr/awprot/awvalid/awready  out/out/out/in  ADDR_WIDTH/3/1/1  AW channel.
- m_axi_wdata/wstrb/wvalid/wready  out/out/out/in  DATA_WIDTH/DATA_WIDTH/8/1/1  W channel.
- m_axi_bresp/bvalid/bready  in/in/out  2/1/1  B channel.
- m_axi_araddr/arprot/arvalid/arready  out/out/out/in  ADDR_WIDTH/3/1/1  AR channel.
- m_axi_rdata/rresp/rvalid/rready  in/in/in/out  DATA_WIDTH/2/1/1  R channel.
- clear  in  1  sync clear of counters and sticky flags.
- busy  out  1  state != IDLE.
- done  out  1  1-cycle pulse when a transaction completes.
- mismatch  out  1  1-cycle pulse, coincident with done, on a read compare fail.
- resp_err  out  1  1-cycle pulse, coincident with done, on bresp/rresp != 2'b00.
- timeout  out  1  1-cycle pulse when the wait counter reaches TIMEOUT_CYCLES.
- sticky_err  out  1  set by mismatch, resp_err or timeout; cleared by clear.
- txn_cnt  out  CNT_WIDTH  completed transactions, saturating.
- mismatch_cnt  out  CNT_WIDTH  read mismatches, saturating.
- last_mismatch_addr  out  ADDR_WIDTH  address of the latest mismatch.

Behaviour:
- Reset: state IDLE. All valid/ready outputs, pulses, counters, sticky_err, last_mismatch_addr and address/data outputs are 0. Reset acts immediately, including mid-transaction; no outstanding transaction is completed afterwards.
- Constant outputs: awprot = arprot = 3'b000; wstrb = all ones.
- cmd_ready = (state==IDLE). On the accept cycle, cmd_* is registered.
- Write path: the cycle after accept, state is WR_REQ with awvalid = wvalid = 1.
  - awvalid and wvalid drop independently, each on its own handshake; both may complete in the same cycle.
  - Once both channels are accepted, go to WR_RESP with bready = 1.
  - On bvalid&&bready: done pulse; resp_err if bresp != 0; return to IDLE.
- Read path: the cycle after accept, state is RD_REQ with arvalid = 1.
  - On arready, go to RD_DATA with rready = 1.
  - On rvalid&&rready: done pulse; resp_err if rresp != 0.
  - If CHECK_READS and rdata != expected data: mismatch pulse, mismatch_cnt increments, last_mismatch_addr <= registered address.
  - Return to IDLE.
- Valids, once asserted, are never dropped before their handshake. AXI outputs are registered, with no combinational path from the slave's ready inputs to the valid outputs.
- Minimum command-to-command spacing: write 3 cycles (accept, AW/W, B), read 3 cycles (accept, AR, R), given zero-wait slave responses.
- Wait counter:
  - Counts every cycle in WR_REQ, WR_RESP, RD_REQ and RD_DATA; reset to 0 on entry to IDLE.
  - When it reaches TIMEOUT_CYCLES: one timeout pulse, sticky_err set, counter holds.
  - Timeout never aborts the transaction; the block keeps waiting.
- Counters saturate at all-ones; no wrap.
- clear: in the same cycle as a count event, clear wins and the counter is 0. clear does not affect the state or the AXI channels.
- Transactions are strictly serialized: at most one outstanding transaction, with no read/write overlap.

Test Plan:
1. Write addr 0x10, data 0xDEADBEEF; slave ready always, bresp 0. Required: cmd handshake at cycle 0; awvalid=wvalid=1 at cycle 1 with awaddr=0x10, wdata=0xDEADBEEF, wstrb=4'hF; bready=1 at cycle 2; done at cycle 2; txn_cnt=1; next cmd_ready at cycle 3.
2. Write with awready at cycle 1 only and wready at cycle 3. Required: awvalid low from cycle 2; wvalid held until cycle 3; bready stays 0 until cycle 4.
3. Read addr 0x20, expected 0x00001234; slave returns 0x1234, then a second read returns 0x1235. Required: first read done with no mismatch; second read gives a mismatch pulse, mismatch_cnt=1, last_mismatch_addr=0x20, sticky_err=1.
4. Write answered with bresp=2'b10. Required: resp_err and done pulse in the same cycle; sticky_err=1; txn_cnt increments. Then apply clear. Required: txn_cnt, mismatch_cnt and sticky_err all 0.
5. TIMEOUT_CYCLES=16; arready held low for 40 cycles. Required: timeout pulses exactly once on the 16th wait cycle; arvalid stays 1 throughout; the read then completes normally with done.
6. anrst_axi asserted while in RD_DATA. Required: rready, busy and counters are 0 immediately. After release: cmd_ready=1, and a new write executes normally.
